// File: rtl/plc_pkg.sv
// Shared definitions for the PLC scan-cycle sequencer.
//   - scan_state_e : 3-bit FSM state encoding. It is also driven out on the
//                    debug 'state' port, so these values are visible outside.
//   - DEF_*        : default parameter values for the sequencer.
package plc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ_IN    = 3'd1,
    ST_EXEC_START = 3'd2,
    ST_EXEC_WAIT  = 3'd3,
    ST_WRITE_OUT  = 3'd4,
    ST_PAD        = 3'd5
  } scan_state_e;

  localparam int DEF_SCAN_PERIOD = 1000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WDT_LIMIT   = 4096;

endpackage

// File: rtl/licznik_okresu.sv
// Saturating up-counter with synchronous clear and a ">= threshold" flag.
// It is used for both the scan-period counter and the EXEC watchdog.
// Ports:
//   clk, rst : clock and synchronous active-high reset (count -> 0)
//   clr      : synchronous clear (has priority over en)
//   en       : count enable; the count holds at all-ones
//   ge       : registered count >= THRESH
module licznik_okresu #(
  parameter int W      = 16,
  parameter int THRESH = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ge
);

  localparam logic [W-1:0] THR = W'(THRESH);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ge = (cnt_q >= THR);

endmodule

// File: rtl/sterownik_cyklu_skanu.sv
// PLC scan-cycle sequencer. Each scan runs these steps in order:
//   1. Read the input image.
//   2. Start one pass of the CPU program and wait for it to finish.
//   3. Write the output image.
//   4. Pad the scan to SCAN_PERIOD cycles, measured from one input read to
//      the next.
//
// Optional feature, selected with macro STEROWNIK_WDT_EN:
//   An EXEC watchdog. If cpu_done does not arrive within WDT_LIMIT
//   EXEC_WAIT cycles, the block:
//     - sets wdt_fault;
//     - goes to IDLE without writing the outputs;
//     - stays in IDLE until rst.
//   Without the macro, wdt_fault is tied to 0 and the block waits for
//   cpu_done indefinitely.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   run         : level; 1 keeps scanning, 0 stops after the current scan
//   cpu_done    : pulse from the CPU; sampled only in EXEC_WAIT
//   in_ce       : one-cycle enable for the input image register (READ_IN)
//   cpu_start   : one-cycle start pulse for the CPU (EXEC_START)
//   out_ce      : one-cycle enable for the output image register (WRITE_OUT)
//   busy        : high in every state except IDLE
//   overrun     : sticky; a scan did not fit in SCAN_PERIOD
//   wdt_fault   : sticky; the EXEC watchdog expired
//   scan_count  : completed scans, wraps around
//   state       : current FSM state (debug)
//
// Handshake: cpu_start is a one-cycle pulse. cpu_done is counted only in a
// cycle spent in EXEC_WAIT. A cpu_done in any other cycle is ignored,
// including the cpu_start cycle itself.
module sterownik_cyklu_skanu
  import plc_pkg::*;
#(
  parameter int SCAN_PERIOD = DEF_SCAN_PERIOD,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WDT_LIMIT   = DEF_WDT_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cpu_done,
  output logic             in_ce,
  output logic             cpu_start,
  output logic             out_ce,
  output logic             busy,
  output logic             overrun,
  output logic             wdt_fault,
  output logic [CNT_W-1:0] scan_count,
  output logic [2:0]       state
);

  scan_state_e      state_q, state_d;
  logic             in_ce_q, in_ce_d;
  logic             cpu_start_q, cpu_start_d;
  logic             out_ce_q, out_ce_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] scan_count_q, scan_count_d;

  logic per_ge;      // cycles since READ_IN >= SCAN_PERIOD-1
  logic wdt_expire;  // watchdog limit reached this cycle, no cpu_done
  logic wdt_block;   // keeps IDLE from restarting after a watchdog fault

  // The period counter reads 0 in the READ_IN cycle, so in any later cycle
  // it holds the number of cycles since the input read. Leaving PAD when it
  // reaches SCAN_PERIOD-1 puts the next READ_IN exactly SCAN_PERIOD cycles
  // after the previous one.
  licznik_okresu #(
    .W      (CNT_W),
    .THRESH (SCAN_PERIOD - 1)
  ) u_period (
    .clk (clk),
    .rst (rst),
    .clr (state_d == ST_READ_IN),
    .en  (state_q != ST_IDLE),
    .ge  (per_ge)
  );

`ifdef STEROWNIK_WDT_EN
  logic wdt_ge;
  logic wdt_fault_q, wdt_fault_d;

  // The watchdog counter reads 0 in the first EXEC_WAIT cycle. It therefore
  // reads WDT_LIMIT-1 in the WDT_LIMIT-th cycle spent waiting.
  licznik_okresu #(
    .W      ($clog2(WDT_LIMIT + 1)),
    .THRESH (WDT_LIMIT - 1)
  ) u_wdt (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_EXEC_WAIT),
    .en  (1'b1),
    .ge  (wdt_ge)
  );

  // If cpu_done arrives in the limit cycle, it wins and the scan completes.
  assign wdt_expire  = (state_q == ST_EXEC_WAIT) && wdt_ge && !cpu_done;
  assign wdt_fault_d = wdt_fault_q | wdt_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_fault_q <= 1'b0;
    end else begin
      wdt_fault_q <= wdt_fault_d;
    end
  end

  assign wdt_block = wdt_fault_q;
  assign wdt_fault = wdt_fault_q;
`else
  // WDT_LIMIT has no effect when the watchdog is not built in.
  localparam logic WDT_OFF = (WDT_LIMIT > 0) ? 1'b0 : 1'b0;

  assign wdt_expire = 1'b0;
  assign wdt_block  = WDT_OFF;
  assign wdt_fault  = WDT_OFF;
`endif

  always_comb begin
    state_d      = state_q;
    overrun_d    = overrun_q;
    scan_count_d = scan_count_q;

    case (state_q)
      ST_IDLE: begin
        if (run && !wdt_block) state_d = ST_READ_IN;
      end
      ST_READ_IN: begin
        state_d = ST_EXEC_START;
      end
      ST_EXEC_START: begin
        state_d = ST_EXEC_WAIT;
      end
      ST_EXEC_WAIT: begin
        if (cpu_done) begin
          state_d = ST_WRITE_OUT;
        end else if (wdt_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE_OUT: begin
        scan_count_d = scan_count_q + CNT_W'(1);
        if (!run) begin
          state_d = ST_IDLE;
        end else if (per_ge) begin
          // This scan used up the whole period. Start the next scan now,
          // without padding.
          overrun_d = 1'b1;
          state_d   = ST_READ_IN;
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (per_ge) begin
          state_d = ST_READ_IN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore outputs are registered from the next state. Each output is
    // therefore high exactly while the FSM occupies the matching state.
    in_ce_d     = (state_d == ST_READ_IN);
    cpu_start_d = (state_d == ST_EXEC_START);
    out_ce_d    = (state_d == ST_WRITE_OUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ce_q      <= 1'b0;
      cpu_start_q  <= 1'b0;
      out_ce_q     <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      scan_count_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ce_q      <= in_ce_d;
      cpu_start_q  <= cpu_start_d;
      out_ce_q     <= out_ce_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      scan_count_q <= scan_count_d;
    end
  end

  assign in_ce      = in_ce_q;
  assign cpu_start  = cpu_start_q;
  assign out_ce     = out_ce_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign scan_count = scan_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_sterownik_cyklu_skanu.sv
// Bench for sterownik_cyklu_skanu: SCAN_PERIOD=20, WDT_LIMIT=8.
// Inputs are driven and outputs sampled on the negative clock edge.
module tb_sterownik_cyklu_skanu;

  localparam int P         = 20;
  localparam int CNT_W     = 16;
  localparam int WDT_LIMIT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             cpu_done;
  logic             in_ce;
  logic             cpu_start;
  logic             out_ce;
  logic             busy;
  logic             overrun;
  logic             wdt_fault;
  logic [CNT_W-1:0] scan_count;
  logic [2:0]       state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int lat;    // cycles from cpu_start to the EXEC_WAIT cycle carrying cpu_done
    bit spur;   // also pulse cpu_done on the cpu_start cycle and in PAD
    int gap;    // expected cycles to the next in_ce
    bit ovr;    // expected overrun after this scan
  } vec_t;

  sterownik_cyklu_skanu #(
    .SCAN_PERIOD (P),
    .CNT_W       (CNT_W),
    .WDT_LIMIT   (WDT_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .cpu_done   (cpu_done),
    .in_ce      (in_ce),
    .cpu_start  (cpu_start),
    .out_ce     (out_ce),
    .busy       (busy),
    .overrun    (overrun),
    .wdt_fault  (wdt_fault),
    .scan_count (scan_count),
    .state      (state)
  );

  // Clock and reset.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish by cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks.
  task automatic do_reset();
    rst      = 1'b1;
    run      = 1'b0;
    cpu_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_in_ce(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ce) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chkn("in_ce_timeout", budget, 0);
  endtask

  // Call this at the negedge of a READ_IN cycle. The task returns at the
  // negedge of the WRITE_OUT cycle.
  task automatic scan(input int lat, input bit spur, input int drop_k);
    @(negedge clk);
    chk1("cpu_start", cpu_start, 1'b1);
    chkn("exec_start_state", int'(state), 2);
    if (spur) cpu_done = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      cpu_done = (k == lat);
      if (k == drop_k) run = 1'b0;
      chkn("exec_wait_state", int'(state), 3);
    end
    @(negedge clk);
    cpu_done = 1'b0;
    chk1("out_ce", out_ce, 1'b1);
    chkn("write_out_state", int'(state), 4);
  endtask

  initial begin
    vec_t vecs[7];
    int   s, at, cnt, lat;
    bit   exp_ovr, seen;

    // All expected gaps below are for P=20. WRITE_OUT falls at offset 2+lat
    // from READ_IN. The scan overruns when 2+lat >= P-1; the next READ_IN
    // then comes one cycle after WRITE_OUT. Otherwise it comes at offset P.
    vecs[0] = '{lat: 5,  spur: 1'b0, gap: 20, ovr: 1'b0};
    vecs[1] = '{lat: 5,  spur: 1'b1, gap: 20, ovr: 1'b0};
    vecs[2] = '{lat: 5,  spur: 1'b0, gap: 20, ovr: 1'b0};
    vecs[3] = '{lat: 16, spur: 1'b0, gap: 20, ovr: 1'b0};
    vecs[4] = '{lat: 17, spur: 1'b0, gap: 20, ovr: 1'b1};
    vecs[5] = '{lat: 25, spur: 1'b0, gap: 28, ovr: 1'b1};
    vecs[6] = '{lat: 1,  spur: 1'b1, gap: 20, ovr: 1'b1};

    rst = 1'b1; run = 1'b0; cpu_done = 1'b0;
    do_reset();
    chkn("rst_state", int'(state), 0);
    chk1("rst_in_ce", in_ce, 1'b0);
    chk1("rst_cpu_start", cpu_start, 1'b0);
    chk1("rst_out_ce", out_ce, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_wdt_fault", wdt_fault, 1'b0);
    chkn("rst_scan_count", int'(scan_count), 0);
    repeat (3) @(negedge clk);
    chkn("idle_hold_state", int'(state), 0);

    // Table-driven scans.
    run = 1'b1;
    @(negedge clk);
    chk1("first_in_ce", in_ce, 1'b1);
    chk1("first_busy", busy, 1'b1);
    s = cyc; cnt = 0;
    for (int i = 0; i < 7; i++) begin
      scan(vecs[i].lat, vecs[i].spur, 0);
      if (vecs[i].spur && (vecs[i].lat + 4 < P)) begin
        @(negedge clk);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        chkn("pad_spurious_state", int'(state), 5);
      end
      wait_in_ce(P + 40, at);
      cnt++;
      chkn("in_ce_gap", at - s, vecs[i].gap);
      chk1("overrun", overrun, vecs[i].ovr);
      chkn("scan_count", int'(scan_count), cnt);
      s = at;
    end

    // Random latencies checked against the timing model.
    do_reset();
    run = 1'b1;
    @(negedge clk);
    chk1("rand_first_in_ce", in_ce, 1'b1);
    s = cyc; cnt = 0; exp_ovr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      lat = int'($urandom_range(1, 24));
      if (lat + 2 >= P - 1) begin
        exp_q.push_back(32'(s + lat + 3));
        exp_ovr = 1'b1;
      end else begin
        exp_q.push_back(32'(s + P));
      end
      cnt++;
      scan(lat, 1'b0, 0);
      wait_in_ce(P + 40, at);
      chkn("rand_in_ce_at", at, int'(exp_q.pop_front()));
      chk1("rand_overrun", overrun, exp_ovr);
      chkn("rand_scan_count", int'(scan_count), cnt);
      s = at;
    end

    // Drop run during EXEC_WAIT. The scan still writes its outputs, then the
    // block stops in IDLE.
    scan(4, 1'b0, 2);
    cnt++;
    @(negedge clk);
    chkn("stop_state", int'(state), 0);
    chk1("stop_busy", busy, 1'b0);
    chkn("stop_scan_count", int'(scan_count), cnt);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (in_ce) seen = 1'b1;
    end
    chk1("stop_no_in_ce", seen, 1'b0);
    run = 1'b1;
    @(negedge clk);
    chk1("restart_in_ce", in_ce, 1'b1);
    chkn("restart_state", int'(state), 1);

    // Drop run during PAD. The block goes to IDLE without emitting a pulse.
    scan(3, 1'b0, 0);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chkn("pad_stop_state", int'(state), 0);
    chk1("pad_stop_out_ce", out_ce, 1'b0);

    // Reset during EXEC_WAIT.
    run = 1'b1;
    wait_in_ce(10, at);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chkn("midrst_state", int'(state), 0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_overrun", overrun, 1'b0);
    chkn("midrst_scan_count", int'(scan_count), 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_ce || cpu_start || in_ce) seen = 1'b1;
    end
    chk1("midrst_no_pulse", seen, 1'b0);

    // Behaviour when cpu_done never arrives.
    run = 1'b1;
    wait_in_ce(10, at);
    @(negedge clk);
`ifdef STEROWNIK_WDT_EN
    repeat (WDT_LIMIT) @(negedge clk);
    chkn("wdt_last_wait_state", int'(state), 3);
    chk1("wdt_not_yet", wdt_fault, 1'b0);
    @(negedge clk);
    chkn("wdt_state", int'(state), 0);
    chk1("wdt_fault", wdt_fault, 1'b1);
    chk1("wdt_no_out_ce", out_ce, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (in_ce || out_ce) seen = 1'b1;
    end
    chk1("wdt_no_restart", seen, 1'b0);
    do_reset();
    chk1("wdt_cleared", wdt_fault, 1'b0);
`else
    repeat (30) @(negedge clk);
    chkn("nowdt_still_waiting", int'(state), 3);
    chk1("nowdt_fault_low", wdt_fault, 1'b0);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    chk1("nowdt_late_out_ce", out_ce, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
